// File: rtl/decode_queue_ctrl.sv
// decode_queue_ctrl: fetch-to-dispatch instruction buffer with WFI halt, illegal-instruction freeze and flush
module decode_queue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       if_valid,
  input  logic [31:0]                if_inst,
  input  logic [31:0]                if_pc,
  output logic                       if_ready,
  input  logic                       flush,
  output logic                       dec_valid,
  output logic [31:0]                dec_inst,
  input  logic                       dec_halt,
  input  logic                       dec_illegal,
  output logic                       dis_valid,
  output logic [31:0]                dis_inst,
  output logic [31:0]                dis_pc,
  input  logic                       dis_ready,
  output logic                       halted,
  output logic                       exception,
  output logic [31:0]                exc_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {RUN, HALTED, EXC} state_t;
  state_t state;
  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic run, push, pop, halt_go, exc_go;
  assign run       = state == RUN;
  assign halted    = state == HALTED;
  assign exception = state == EXC;
  assign if_ready  = run && count != CW'(DEPTH) && !flush;
  assign dec_valid = run && count != '0;
  assign dec_inst  = count != '0 ? inst_q[head] : '0;
  assign dis_valid = dec_valid && !dec_illegal && !flush;
  assign dis_inst  = inst_q[head];
  assign dis_pc    = pc_q[head];
  assign push      = if_valid && if_ready;
  assign pop       = dis_valid && dis_ready;
  assign halt_go   = pop && dec_halt;
  assign exc_go    = dec_valid && dec_illegal && !flush;
  always_ff @(posedge clock) begin
    if (push) begin
      inst_q[tail] <= if_inst;
      pc_q[tail]   <= if_pc;
    end
  end
  // Halt and exception both drop whatever else is buffered behind the head.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      exc_pc <= '0;
    end else if (flush) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (halt_go || exc_go) begin
      state  <= halt_go ? HALTED : EXC;
      exc_pc <= exc_go ? pc_q[head] : exc_pc;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
